// File: rtl/bidir_port_pkg.sv
// Shared types and constants for the bidirectional pad port controller.
// BIDIR_PORT_SYNC_EN selects a two-flop pad_i synchronizer instead of one register.
package bidir_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_TURN   = 2'd2,
        ST_SAMPLE = 2'd3
    } state_t;

    localparam int CNT_W = 4;

`ifdef BIDIR_PORT_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif

endpackage

// File: rtl/bidir_port_sync.sv
// WIDTH-wide register chain for the asynchronous pad readback; depth is SYNC_STAGES.
// Stage count follows BIDIR_PORT_SYNC_EN through bidir_port_pkg.
module bidir_port_sync
    import bidir_port_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_port_ctrl.sv
// Bidirectional pad controller: drives pads for a write, releases them for a
// turnaround, and samples synchronized pads for a read. Macro: BIDIR_PORT_SYNC_EN.
module bidir_port_ctrl
    import bidir_port_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DRIVE_CYCLES = 2,
    parameter int TURN_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             wr_done,
    output logic             busy,
    output logic [WIDTH-1:0] pad_o,
    output logic             pad_t,
    input  logic [WIDTH-1:0] pad_i,
    output logic [1:0]       dbg_state
);

    // Handshake: a request is taken only on an edge where busy=0; requests seen
    // while busy are dropped. wr_done / rd_valid are single-cycle completion pulses.

    localparam logic [CNT_W-1:0] DRIVE_LD  = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SYNC_STAGES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pad_o_q, rd_data_q, sync_q;
    logic             rd_valid_q, wr_done_q;
    logic             load_wr, wr_fin, rd_fin;

    bidir_port_sync #(.WIDTH(WIDTH)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pad_i),
        .q       (sync_q)
    );

    // Counter holds remaining cycles minus one; it is reloaded on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_wr = 1'b0;
        wr_fin  = 1'b0;
        rd_fin  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    state_d = ST_DRIVE;
                    cnt_d   = DRIVE_LD;
                    load_wr = 1'b1;
                end else if (rd_req) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = SAMPLE_LD;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = ST_TURN;
                    cnt_d   = TURN_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    wr_fin  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    rd_fin  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pad_o_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_fin;
            wr_done_q  <= wr_fin;
            if (load_wr) pad_o_q   <= wr_data;
            if (rd_fin)  rd_data_q <= sync_q;
        end
    end

    // The bus is driven only in DRIVE, so a read can never leave it driven.
    assign pad_t     = (state_q != ST_DRIVE);
    assign busy      = (state_q != ST_IDLE);
    assign pad_o     = pad_o_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign wr_done   = wr_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Bench for bidir_port_ctrl: default instance plus a 15/15 timing instance.
// Honours BIDIR_PORT_SYNC_EN for the expected read latency.
module tb_bidir_port_ctrl;

`ifdef BIDIR_PORT_SYNC_EN
    localparam int SYNC_S = 2;
`else
    localparam int SYNC_S = 1;
`endif
    localparam int RD_LAT = SYNC_S + 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_req_a = 1'b0, wr_req_x = 1'b0, rd_req_a = 1'b0;
    logic [7:0] wr_data_a = '0, wr_data_x = '0, pad_i = '0;

    logic [7:0] rd_data_a, pad_o_a, rd_data_x, pad_o_x;
    logic       rd_valid_a, wr_done_a, busy_a, pad_t_a;
    logic       rd_valid_x, wr_done_x, busy_x, pad_t_x;
    logic [1:0] dbg_a, dbg_x;

    logic       sel = 1'b0;
    logic [7:0] pad_o_s;
    logic       pad_t_s, busy_s, wr_done_s;
    assign pad_o_s   = sel ? pad_o_x   : pad_o_a;
    assign pad_t_s   = sel ? pad_t_x   : pad_t_a;
    assign busy_s    = sel ? busy_x    : busy_a;
    assign wr_done_s = sel ? wr_done_x : wr_done_a;

    logic [7:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bidir_port_ctrl dut (
        .clk(clk), .reset_n(reset_n), .wr_req(wr_req_a), .wr_data(wr_data_a),
        .rd_req(rd_req_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .wr_done(wr_done_a), .busy(busy_a), .pad_o(pad_o_a), .pad_t(pad_t_a),
        .pad_i(pad_i), .dbg_state(dbg_a)
    );

    bidir_port_ctrl #(.WIDTH(8), .DRIVE_CYCLES(15), .TURN_CYCLES(15)) dut_x (
        .clk(clk), .reset_n(reset_n), .wr_req(wr_req_x), .wr_data(wr_data_x),
        .rd_req(1'b0), .rd_data(rd_data_x), .rd_valid(rd_valid_x),
        .wr_done(wr_done_x), .busy(busy_x), .pad_o(pad_o_x), .pad_t(pad_t_x),
        .pad_i(pad_i), .dbg_state(dbg_x)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic s, input logic [7:0] d, input int dc, input int tc);
        logic [7:0] e;
        sel = s;
        if (s) begin wr_req_x = 1'b1; wr_data_x = d; end
        else   begin wr_req_a = 1'b1; wr_data_a = d; end
        exp_q.push_back(d);
        step();
        wr_req_a = 1'b0;
        wr_req_x = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        for (int i = 0; i < dc; i++) begin
            if (i > 0) step();
            check("drv_pad_t", pad_t_s, 1'b0);
            check("drv_pad_o", pad_o_s, e);
            check("drv_busy", busy_s, 1'b1);
        end
        for (int i = 0; i < tc; i++) begin
            step();
            check("turn_pad_t", pad_t_s, 1'b1);
            check("turn_pad_o", pad_o_s, e);
            check("turn_busy", busy_s, 1'b1);
            check("turn_wr_done", wr_done_s, 1'b0);
        end
        step();
        check("wr_done_pulse", wr_done_s, 1'b1);
        check("wr_idle_busy", busy_s, 1'b0);
        step();
        check("wr_done_clear", wr_done_s, 1'b0);
        sel = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] d);
        logic [7:0] e;
        int n;
        logic got;
        pad_i    = d;
        rd_req_a = 1'b1;
        exp_q.push_back(d);
        step();
        rd_req_a = 1'b0;
        check("rd_busy", busy_a, 1'b1);
        check("rd_pad_t", pad_t_a, 1'b1);
        got = 1'b0;
        n   = 0;
        while (!got && n < 10) begin
            step();
            n++;
            check("rd_pad_t_hold", pad_t_a, 1'b1);
            if (rd_valid_a) got = 1'b1;
        end
        if (got) begin
            check("rd_latency", n + 1, RD_LAT);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            check("rd_data", rd_data_a, e);
            check("rd_done_busy", busy_a, 1'b0);
        end else begin
            check("rd_timeout", 1'b0, 1'b1);
            void'(exp_q.pop_front());
        end
        step();
        check("rd_valid_clear", rd_valid_a, 1'b0);
        check("rd_after_pad_t", pad_t_a, 1'b1);
        check("rd_data_hold", rd_data_a, d);
    endtask

    initial begin
        int rv, wd;
        logic [7:0] r;

        // Reset held for two edges
        reset_n = 1'b0;
        step();
        step();
        check("rst_pad_t", pad_t_a, 1'b1);
        check("rst_pad_o", pad_o_a, 8'h00);
        check("rst_rd_data", rd_data_a, 8'h00);
        check("rst_rd_valid", rd_valid_a, 1'b0);
        check("rst_wr_done", wr_done_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_state", dbg_a, 2'd0);
        check("rst_x_pad_t", pad_t_x, 1'b1);
        reset_n = 1'b1;
        step();

        do_write(1'b0, 8'hA5, 2, 1);
        do_read(8'h3C);
        check("rd_hold_after_wr", rd_data_a, 8'h3C);

        // Write and read together: write wins, read is dropped
        pad_i     = 8'hC3;
        wr_req_a  = 1'b1;
        rd_req_a  = 1'b1;
        wr_data_a = 8'h11;
        step();
        wr_req_a = 1'b0;
        rd_req_a = 1'b0;
        check("sim_pad_t", pad_t_a, 1'b0);
        check("sim_pad_o", pad_o_a, 8'h11);
        rd_req_a = 1'b1;
        step();
        rd_req_a = 1'b0;
        rv = 0;
        wd = 0;
        for (int i = 0; i < 10; i++) begin
            if (rd_valid_a) rv++;
            if (wr_done_a) wd++;
            step();
        end
        check("sim_no_rd_valid", rv, 0);
        check("sim_one_wr_done", wd, 1);
        check("sim_rd_data_kept", rd_data_a, 8'h3C);
        check("sim_idle", busy_a, 1'b0);

        // Reset during DRIVE aborts the write without wr_done
        wr_req_a  = 1'b1;
        wr_data_a = 8'h5A;
        step();
        wr_req_a = 1'b0;
        check("abort_driving", pad_t_a, 1'b0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("abort_pad_t", pad_t_a, 1'b1);
        check("abort_busy", busy_a, 1'b0);
        check("abort_pad_o", pad_o_a, 8'h00);
        check("abort_rd_data", rd_data_a, 8'h00);
        wd = 0;
        for (int i = 0; i < 6; i++) begin
            if (wr_done_a) wd++;
            step();
        end
        check("abort_no_wr_done", wd, 0);

        // Random read/write mix on the default instance
        for (int k = 0; k < 4; k++) begin
            r = 8'($urandom_range(0, 255));
            do_write(1'b0, r, 2, 1);
            r = 8'($urandom_range(0, 255));
            do_read(r);
        end

        // Longest timing: 15 driven and 15 released cycles
        do_write(1'b1, 8'h96, 15, 15);
        do_write(1'b1, 8'h69, 15, 15);

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
